// File: rtl/spr_rend.sv
// Single-sprite scanline renderer: a pending/active slice pair swapped at end of line,
// producing a registered palette index and opaque flag one pixel clock after PIXEL_X.
module spr_rend (
   input  logic        PPU_SLOW_CLOCK,
   input  logic        RST,
   input  logic [31:0] SPR_DATA,
   input  logic [9:0]  PIXEL_X,
   input  logic        LOAD,
   input  logic        ENABLE,
   output logic [3:0]  PAL_COLOUR,
   output logic        VALID
);

   localparam logic [9:0] LAST_COL    = 10'd339;
   localparam logic [9:0] VISIBLE_END = 10'd256;

   logic [31:0] pend_q, pend_d;
   logic [31:0] act_q, act_d;
   logic        pend_ld_q, pend_ld_d;
   logic        act_ld_q, act_ld_d;
   logic [3:0]  colour_q, colour_d;
   logic        valid_q, valid_d;

   logic [9:0]  spr_x;
   logic [9:0]  off;
   logic        in_range;
   logic        h_flip;
   logic [2:0]  idx;
   logic [7:0]  lsb_plane;
   logic [7:0]  msb_plane;
   logic [3:0]  colour;
   logic        opaque;
   logic        attr_unused;

   // Priority and vertical-flip attribute bits are consumed elsewhere in the pipeline.
   assign attr_unused = ^{act_q[31], act_q[29:26]};

   always_comb begin
      pend_d    = pend_q;
      pend_ld_d = pend_ld_q;
      act_d     = act_q;
      act_ld_d  = act_ld_q;

      // Swap reads the pre-edge pending buffer, so a same-edge LOAD lands for the next line.
      if (PIXEL_X == LAST_COL) begin
         act_d     = pend_q;
         act_ld_d  = pend_ld_q;
         pend_ld_d = 1'b0;
      end
      if (LOAD) begin
         pend_d    = SPR_DATA;
         pend_ld_d = 1'b1;
      end
   end

   always_comb begin
      lsb_plane = act_q[7:0];
      msb_plane = act_q[15:8];
      h_flip    = act_q[30];
      spr_x     = {2'b00, act_q[23:16]};
      off       = PIXEL_X - spr_x;
      // Full 10-bit compare: sprites near the right edge never wrap into column 0.
      in_range  = (PIXEL_X >= spr_x) && (off < 10'd8) && (PIXEL_X < VISIBLE_END);
      idx       = h_flip ? off[2:0] : (3'd7 - off[2:0]);
      colour    = {act_q[25:24], msb_plane[idx], lsb_plane[idx]};
      opaque    = (colour[1:0] != 2'b00);

      valid_d   = ENABLE && act_ld_q && in_range && opaque;
      colour_d  = valid_d ? colour : 4'h0;
   end

   always_ff @(posedge PPU_SLOW_CLOCK) begin
      if (!RST) begin
         pend_q    <= '0;
         act_q     <= '0;
         pend_ld_q <= 1'b0;
         act_ld_q  <= 1'b0;
         colour_q  <= 4'h0;
         valid_q   <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         act_q     <= act_d;
         pend_ld_q <= pend_ld_d;
         act_ld_q  <= act_ld_d;
         colour_q  <= colour_d;
         valid_q   <= valid_d;
      end
   end

   assign PAL_COLOUR = colour_q;
   assign VALID      = valid_q;

endmodule

// File: tb/tb_spr_rend.sv
// Directed bench for spr_rend: a table of single-pixel vectors plus hand-written
// sequences for line swapping, gating and reset behaviour.
module tb_spr_rend;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] spr_data;
   logic [9:0]  pixel_x;
   logic        load;
   logic        enable;
   logic [3:0]  pal_colour;
   logic        valid;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] SPR_A    = 32'h0210_F00F; // X=16, palette 2, no flip
   localparam logic [31:0] SPR_B    = 32'h4120_0080; // X=32, palette 1, flipped
   localparam logic [31:0] SPR_C    = 32'h00FC_00FF; // X=252, right-edge clip
   localparam logic [31:0] SPR_D    = 32'h00FA_00FF; // X=250, must not wrap
   localparam logic [31:0] SPR_E    = 32'hA310_F00F; // bits 7/5 set, palette 3
   localparam logic [31:0] SPR_F    = 32'h4210_F00F; // A with horizontal flip
   localparam logic [31:0] SPR_ZERO = 32'h0000_0000;

   always #5 clk = ~clk;

   spr_rend dut (
      .PPU_SLOW_CLOCK(clk),
      .RST           (rst_n),
      .SPR_DATA      (spr_data),
      .PIXEL_X       (pixel_x),
      .LOAD          (load),
      .ENABLE        (enable),
      .PAL_COLOUR    (pal_colour),
      .VALID         (valid)
   );

   typedef struct {
      string       name;
      logic [31:0] spr;
      logic [9:0]  px;
      logic        en;
      logic        exp_v;
      logic [3:0]  exp_c;
   } vec_t;

   vec_t vecs[$];

   task automatic step(input logic [9:0] px, input logic ld, input logic [31:0] d);
      @(negedge clk);
      pixel_x  = px;
      load     = ld;
      spr_data = d;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic chk(input string nm, input logic ev, input logic [3:0] ec);
      checks++;
      if (valid !== ev || pal_colour !== ec) begin
         errors++;
         $display("FAIL %s px=%0d: got VALID=%b PAL_COLOUR=%h, expected VALID=%b PAL_COLOUR=%h",
                  nm, pixel_x, valid, pal_colour, ev, ec);
      end else begin
         $display("ok   %s px=%0d VALID=%b PAL_COLOUR=%h", nm, pixel_x, valid, pal_colour);
      end
   endtask

   task automatic load_line(input logic [31:0] d);
      step(10'd300, 1'b1, d);
      step(10'd339, 1'b0, SPR_ZERO);
   endtask

   task automatic add(input string n, input logic [31:0] s, input int lo, input int hi,
                      input logic en, input logic v, input logic [3:0] c);
      for (int p = lo; p <= hi; p++) vecs.push_back('{n, s, 10'(p), en, v, c});
   endtask

   initial begin
      rst_n    = 1'b0;
      spr_data = '0;
      pixel_x  = '0;
      load     = 1'b0;
      enable   = 1'b1;

      // Reset state, then nothing loaded yet must stay dark.
      step(10'd16, 1'b0, SPR_ZERO);
      step(10'd17, 1'b0, SPR_ZERO);
      chk("reset_state", 1'b0, 4'h0);
      rst_n = 1'b1;
      step(10'd16, 1'b0, SPR_ZERO);
      chk("unloaded_dark", 1'b0, 4'h0);

      // Single-pixel vector table.
      add("noflip_edge_lo", SPR_A, 15, 15, 1'b1, 1'b0, 4'h0);
      add("noflip_msb",     SPR_A, 16, 19, 1'b1, 1'b1, 4'hA);
      add("noflip_lsb",     SPR_A, 20, 23, 1'b1, 1'b1, 4'h9);
      add("noflip_edge_hi", SPR_A, 24, 24, 1'b1, 1'b0, 4'h0);
      add("flip_transp",    SPR_B, 32, 38, 1'b1, 1'b0, 4'h0);
      add("flip_opaque",    SPR_B, 39, 39, 1'b1, 1'b1, 4'h5);
      add("flip_after",     SPR_B, 40, 40, 1'b1, 1'b0, 4'h0);
      add("clip_in",        SPR_C, 252, 255, 1'b1, 1'b1, 4'h1);
      add("clip_out",       SPR_C, 256, 259, 1'b1, 1'b0, 4'h0);
      add("nowrap_left",    SPR_D, 0, 1, 1'b1, 1'b0, 4'h0);
      add("nowrap_draw",    SPR_D, 250, 250, 1'b1, 1'b1, 4'h1);
      add("attr_ign_msb",   SPR_E, 16, 16, 1'b1, 1'b1, 4'hE);
      add("attr_ign_lsb",   SPR_E, 20, 20, 1'b1, 1'b1, 4'hD);
      add("flip_first",     SPR_F, 16, 16, 1'b1, 1'b1, 4'h9);
      add("flip_last",      SPR_F, 23, 23, 1'b1, 1'b1, 4'hA);
      add("gate_off",       SPR_A, 16, 16, 1'b0, 1'b0, 4'h0);

      foreach (vecs[i]) begin
         enable = vecs[i].en;
         load_line(vecs[i].spr);
         step(vecs[i].px, 1'b0, SPR_ZERO);
         chk(vecs[i].name, vecs[i].exp_v, vecs[i].exp_c);
      end
      enable = 1'b1;

      // Line swap: A shows for one line only, and a LOAD at column 339 skips a line.
      load_line(SPR_A);
      step(10'd16, 1'b0, SPR_ZERO);
      chk("swap_line1", 1'b1, 4'hA);
      step(10'd339, 1'b0, SPR_ZERO);
      step(10'd16, 1'b0, SPR_ZERO);
      chk("swap_line2_dark", 1'b0, 4'h0);
      step(10'd20, 1'b0, SPR_ZERO);
      chk("swap_line2_dark", 1'b0, 4'h0);
      step(10'd339, 1'b1, SPR_B);
      step(10'd39, 1'b0, SPR_ZERO);
      chk("late_load_not_yet", 1'b0, 4'h0);
      step(10'd339, 1'b0, SPR_ZERO);
      step(10'd39, 1'b0, SPR_ZERO);
      chk("late_load_shown", 1'b1, 4'h5);
      step(10'd339, 1'b0, SPR_ZERO);
      step(10'd39, 1'b0, SPR_ZERO);
      chk("late_load_gone", 1'b0, 4'h0);

      // Gating over a loaded line, then resume without reloading.
      load_line(SPR_A);
      enable = 1'b0;
      for (int p = 16; p <= 23; p++) begin
         step(10'(p), 1'b0, SPR_ZERO);
         chk("gate_line", 1'b0, 4'h0);
      end
      enable = 1'b1;
      step(10'd16, 1'b0, SPR_ZERO);
      chk("gate_resume", 1'b1, 4'hA);

      // Mid-line reset with a further sprite sitting in pending.
      load_line(SPR_A);
      step(10'd16, 1'b0, SPR_ZERO);
      chk("pre_reset_draw", 1'b1, 4'hA);
      step(10'd17, 1'b1, SPR_A);
      rst_n = 1'b0;
      step(10'd18, 1'b0, SPR_ZERO);
      chk("reset_midline", 1'b0, 4'h0);
      rst_n = 1'b1;
      step(10'd19, 1'b0, SPR_ZERO);
      chk("reset_after", 1'b0, 4'h0);
      step(10'd339, 1'b0, SPR_ZERO);
      step(10'd16, 1'b0, SPR_ZERO);
      chk("reset_line1", 1'b0, 4'h0);
      step(10'd339, 1'b0, SPR_ZERO);
      step(10'd16, 1'b0, SPR_ZERO);
      chk("reset_line2", 1'b0, 4'h0);

      // Reset outranks a simultaneous LOAD and swap.
      load_line(SPR_A);
      rst_n = 1'b0;
      step(10'd339, 1'b1, SPR_A);
      rst_n = 1'b1;
      step(10'd16, 1'b0, SPR_ZERO);
      chk("reset_over_swap", 1'b0, 4'h0);
      step(10'd339, 1'b0, SPR_ZERO);
      step(10'd16, 1'b0, SPR_ZERO);
      chk("reset_over_load", 1'b0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
